// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32 control sequencer with an APB requester port; defining SYS_TRAP_EN adds the trap save/vector sequence
module control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       pready,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       microop_pc_zero,
    output logic       mem_access,
    output logic       mem_access_rdy,
    output logic       sys_load,
    output logic       sys_load_pc,
    output logic       store_alu,
    output logic       immediate,
    output logic       alu_rs1,
    output logic       alu_imm_i,
    output logic       lui_flag,
    output logic       jal_flag,
    output logic       load_jalr,
    output logic       load_pc,
    output logic       load_branch
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    typedef enum logic [3:0] {
        FETCH_SETUP, FETCH_ACCESS, EXECUTE, MEM_SETUP, MEM_ACCESS
`ifdef SYS_TRAP_EN
        , TRAP_SAVE_SETUP, TRAP_SAVE_ACCESS, TRAP_VEC_SETUP, TRAP_VEC_ACCESS, TRAP_LOAD
`endif
    } state_t;
    state_t state;
    logic op_r, op_i, op_lui, op_jal, op_jalr, op_br, op_ld, op_st;
    logic s_fs, s_fa, s_ex, s_ms, s_ma;
    logic s_tss, s_tsa, s_tvs, s_tva, s_tl;
    assign op_r    = opcode == OP_R;
    assign op_i    = opcode == OP_I;
    assign op_lui  = opcode == OP_LUI || opcode == OP_AUIPC;
    assign op_jal  = opcode == OP_JAL;
    assign op_jalr = opcode == OP_JALR;
    assign op_br   = opcode == OP_BR;
    assign op_ld   = opcode == OP_LD;
    assign op_st   = opcode == OP_ST;
    // state decodes are qualified by rst_n so every output drops to 0 the moment reset asserts
    assign s_fs = rst_n && state == FETCH_SETUP;
    assign s_fa = rst_n && state == FETCH_ACCESS;
    assign s_ex = rst_n && state == EXECUTE;
    assign s_ms = rst_n && state == MEM_SETUP;
    assign s_ma = rst_n && state == MEM_ACCESS;
`ifdef SYS_TRAP_EN
    logic known;
    assign known = op_r || op_i || op_lui || op_jal || op_jalr || op_br || op_ld || op_st;
    assign s_tss = rst_n && state == TRAP_SAVE_SETUP;
    assign s_tsa = rst_n && state == TRAP_SAVE_ACCESS;
    assign s_tvs = rst_n && state == TRAP_VEC_SETUP;
    assign s_tva = rst_n && state == TRAP_VEC_ACCESS;
    assign s_tl  = rst_n && state == TRAP_LOAD;
`else
    assign s_tss = 1'b0;
    assign s_tsa = 1'b0;
    assign s_tvs = 1'b0;
    assign s_tva = 1'b0;
    assign s_tl  = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_SETUP;
        end else begin
            case (state)
                FETCH_SETUP:      state <= FETCH_ACCESS;
                FETCH_ACCESS:     state <= pready ? EXECUTE : FETCH_ACCESS;
`ifdef SYS_TRAP_EN
                EXECUTE:          state <= (op_ld || op_st) ? MEM_SETUP : !known ? TRAP_SAVE_SETUP : FETCH_SETUP;
                TRAP_SAVE_SETUP:  state <= TRAP_SAVE_ACCESS;
                TRAP_SAVE_ACCESS: state <= pready ? TRAP_VEC_SETUP : TRAP_SAVE_ACCESS;
                TRAP_VEC_SETUP:   state <= TRAP_VEC_ACCESS;
                TRAP_VEC_ACCESS:  state <= pready ? TRAP_LOAD : TRAP_VEC_ACCESS;
                TRAP_LOAD:        state <= FETCH_SETUP;
`else
                EXECUTE:          state <= (op_ld || op_st) ? MEM_SETUP : FETCH_SETUP;
`endif
                MEM_SETUP:        state <= MEM_ACCESS;
                MEM_ACCESS:       state <= pready ? FETCH_SETUP : MEM_ACCESS;
                default:          state <= FETCH_SETUP;
            endcase
        end
    end
    assign psel            = s_fs | s_fa | s_ms | s_ma | s_tss | s_tsa | s_tvs | s_tva;
    assign penable         = s_fa | s_ma | s_tsa | s_tva;
    assign pwrite          = ((s_ms | s_ma) & op_st) | s_tss | s_tsa;
    assign microop_pc_zero = s_fs | s_fa;
    assign mem_access      = s_ms | s_ma;
    assign mem_access_rdy  = s_ma & pready & op_ld;
    assign ir_we           = (s_fa | s_tva) & pready;
    assign pc_we           = (s_fa & pready) | (s_ex & (op_jal | op_jalr | (op_br & branch_taken))) | s_tl;
    assign reg_we          = (s_ex & (op_r | op_i | op_lui | op_jal | op_jalr)) | mem_access_rdy;
    assign sys_load        = s_tss | s_tsa | s_tvs | s_tva;
    assign sys_load_pc     = s_tl;
    assign store_alu       = s_ex & (op_r | op_i);
    assign immediate       = s_ex & op_i;
    assign alu_rs1         = s_ex & (op_r | op_br);
    assign alu_imm_i       = s_ex & (op_i | op_jalr);
    assign lui_flag        = s_ex & op_lui;
    assign jal_flag        = s_ex & op_jal;
    assign load_jalr       = s_ex & op_jalr;
    assign load_pc         = s_ex & op_jalr;
    assign load_branch     = s_ex & op_br & branch_taken;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: per-cycle output trace of control_fsm compared against a transaction-level expected trace
module tb_control_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] opcode = 7'h00;
    logic branch_taken = 1'b0;
    logic pready = 1'b1;
    logic psel, penable, pwrite, ir_we, pc_we, reg_we, microop_pc_zero, mem_access, mem_access_rdy;
    logic sys_load, sys_load_pc, store_alu, immediate, alu_rs1, alu_imm_i, lui_flag, jal_flag;
    logic load_jalr, load_pc, load_branch;
    int checks = 0;
    int fails = 0;
    always #5 clk = ~clk;
    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken), .pready(pready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .microop_pc_zero(microop_pc_zero), .mem_access(mem_access), .mem_access_rdy(mem_access_rdy),
        .sys_load(sys_load), .sys_load_pc(sys_load_pc), .store_alu(store_alu), .immediate(immediate),
        .alu_rs1(alu_rs1), .alu_imm_i(alu_imm_i), .lui_flag(lui_flag), .jal_flag(jal_flag),
        .load_jalr(load_jalr), .load_pc(load_pc), .load_branch(load_branch)
    );
    logic [19:0] outs;
    assign outs = {psel, penable, pwrite, ir_we, pc_we, reg_we, microop_pc_zero, mem_access, mem_access_rdy,
                   sys_load, sys_load_pc, store_alu, immediate, alu_rs1, alu_imm_i, lui_flag, jal_flag,
                   load_jalr, load_pc, load_branch};
    localparam logic [19:0] SEL = 20'h80000, EN = 20'h40000, WR = 20'h20000, IR = 20'h10000;
    localparam logic [19:0] PCW = 20'h08000, RW = 20'h04000, PCZ = 20'h02000, MEM = 20'h01000;
    localparam logic [19:0] RDY = 20'h00800, SL = 20'h00400, SLPC = 20'h00200, SA = 20'h00100;
    localparam logic [19:0] IMM = 20'h00080, RS1 = 20'h00040, AII = 20'h00020, LUI = 20'h00010;
    localparam logic [19:0] JAL = 20'h00008, LJ = 20'h00004, LP = 20'h00002, LB = 20'h00001;
    function automatic logic [19:0] exec_vec(input logic [6:0] op, input logic bt);
        case (op)
            7'h33:        return SA | RS1 | RW;
            7'h13:        return SA | IMM | AII | RW;
            7'h37, 7'h17: return LUI | RW;
            7'h6F:        return JAL | PCW | RW;
            7'h67:        return LJ | LP | AII | PCW | RW;
            7'h63:        return RS1 | (bt ? (LB | PCW) : 20'h0);
            default:      return 20'h0;
        endcase
    endfunction
    function automatic bit is_known(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
    endfunction
    task automatic check(input string tag, input logic [19:0] want);
        checks++;
        assert (outs === want) else begin
            fails++;
            $error("FAIL %s op=%h: observed %h expected %h", tag, opcode, outs, want);
        end
    endtask
    // one APB transfer: setup cycle, waits, then the completing access cycle
    task automatic push_xfer(inout logic [19:0] ev[$], inout bit pr[$], input logic [19:0] base,
                             input int waits, input logic [19:0] done);
        ev.push_back(SEL | base);
        pr.push_back(1'($urandom));
        for (int w = 0; w < waits; w++) begin
            ev.push_back(SEL | EN | base);
            pr.push_back(1'b0);
        end
        ev.push_back(SEL | EN | base | done);
        pr.push_back(1'b1);
    endtask
    // entered #1 after a rising edge with the DUT in FETCH_SETUP; leaves it in the same position
    task automatic run_instr(input logic [6:0] op, input logic bt, input int fw, input int mw);
        logic [19:0] ev[$];
        bit pr[$];
        int ex;
        push_xfer(ev, pr, PCZ, fw, IR | PCW);
        ex = ev.size();
        ev.push_back(exec_vec(op, bt));
        pr.push_back(1'($urandom));
        if (op == 7'h03) push_xfer(ev, pr, MEM, mw, RDY | RW);
        if (op == 7'h23) push_xfer(ev, pr, MEM | WR, mw, 20'h0);
`ifdef SYS_TRAP_EN
        if (!is_known(op)) begin
            push_xfer(ev, pr, SL | WR, mw, 20'h0);
            push_xfer(ev, pr, SL, fw, IR);
            ev.push_back(SLPC | PCW);
            pr.push_back(1'($urandom));
        end
`endif
        opcode = op;
        for (int i = 0; i < ev.size(); i++) begin
            pready = pr[i];
            branch_taken = (i == ex) ? bt : 1'($urandom);
            @(negedge clk);
            check($sformatf("cycle%0d", i + 1), ev[i]);
            @(posedge clk);
            #1;
        end
    endtask
    task automatic abort_fetch(input logic [6:0] op, input logic pr_in_reset);
        opcode = op;
        pready = 1'b1;
        @(negedge clk);
        check("abort_fs", SEL | PCZ);
        @(posedge clk);
        #1 pready = 1'b0;
        @(negedge clk);
        check("abort_fa", SEL | EN | PCZ);
        #2 rst_n = 1'b0;
        pready = pr_in_reset;
        #1 check("abort_async", 20'h0);
        @(posedge clk);
        #1 check("abort_held", 20'h0);
        rst_n = 1'b1;
    endtask
    logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h73, 7'h00};
    initial begin
        @(posedge clk);
        #1 check("reset_low", 20'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(7'h33, 1'b0, 0, 0);
        run_instr(7'h03, 1'b0, 0, 2);
        run_instr(7'h23, 1'b0, 1, 0);
        run_instr(7'h63, 1'b0, 0, 0);
        run_instr(7'h63, 1'b1, 0, 0);
        run_instr(7'h73, 1'b0, 0, 0);
        run_instr(7'h7F, 1'b1, 1, 1);
        abort_fetch(7'h33, 1'b1);
        run_instr(7'h33, 1'b0, 0, 0);
        abort_fetch(7'h03, 1'b0);
        run_instr(7'h03, 1'b1, 0, 0);
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 10)];
            if (op == 7'h00) op = 7'($urandom);
            run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
